// File: rtl/serial_div.sv
// Sequential signed restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Start/valid handshake; results and status flags hold until the next operation completes.
module serial_div (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic [15:0] in_n,
   input  logic [7:0]  in_d,
   output logic [15:0] Quotient,
   output logic [7:0]  Remainder,
   output logic        Busy,
   output logic        Quotient_Valid,
   output logic        Div_Zero,
   output logic        Overflow
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e state_q, state_d;

   logic        load_en, iter_en, fix_en;

   // dvd_q holds the dividend magnitude; quotient bits shift in at the LSB as it empties.
   logic [15:0] dvd_q, dvd_d;
   logic [7:0]  dmag_q, dmag_d;
   logic [8:0]  prem_q, prem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        qs_q, qs_d;
   logic        rs_q, rs_d;
   logic        dz_q, dz_d;
   logic        ov_q, ov_d;

   logic [15:0] quot_q, quot_d;
   logic [7:0]  rem_q, rem_d;
   logic        valid_q, valid_d;
   logic        dz_out_q, dz_out_d;
   logic        ov_out_q, ov_out_d;

   logic [15:0] n_mag;
   logic [7:0]  d_mag;
   logic [9:0]  prem_shift;
   logic [8:0]  prem_diff;
   logic        prem_ge;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (Start) state_d = StCalc;
         StCalc: if (cnt_q == 5'd15) state_d = StFix;
         StFix:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      load_en = (state_q == StIdle) && Start;
      iter_en = (state_q == StCalc);
      fix_en  = (state_q == StFix);
      Busy    = (state_q != StIdle);
   end

   always_comb begin
      n_mag      = in_n[15] ? -in_n : in_n;
      d_mag      = in_d[7] ? -in_d : in_d;
      prem_shift = {prem_q, dvd_q[15]};
      prem_ge    = prem_shift >= {2'b00, dmag_q};
      prem_diff  = prem_shift[8:0] - {1'b0, dmag_q};
   end

   always_comb begin
      dvd_d    = dvd_q;
      dmag_d   = dmag_q;
      prem_d   = prem_q;
      cnt_d    = cnt_q;
      qs_d     = qs_q;
      rs_d     = rs_q;
      dz_d     = dz_q;
      ov_d     = ov_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      valid_d  = 1'b0;
      dz_out_d = dz_out_q;
      ov_out_d = ov_out_q;

      if (load_en) begin
         dvd_d  = n_mag;
         dmag_d = d_mag;
         prem_d = 9'd0;
         cnt_d  = 5'd0;
         qs_d   = in_n[15] ^ in_d[7];
         rs_d   = in_n[15];
         dz_d   = (in_d == 8'h00);
         ov_d   = (in_n == 16'h8000) && (in_d == 8'hFF);
      end

      if (iter_en) begin
         prem_d = prem_ge ? prem_diff : prem_shift[8:0];
         dvd_d  = {dvd_q[14:0], prem_ge};
         cnt_d  = cnt_q + 5'd1;
      end

      if (fix_en) begin
         valid_d  = 1'b1;
         dz_out_d = dz_q;
         ov_out_d = ov_q && !dz_q;
         if (dz_q) begin
            quot_d = rs_q ? 16'h8000 : 16'h7FFF;
            rem_d  = 8'h00;
         end else if (ov_q) begin
            quot_d = 16'h8000;
            rem_d  = 8'h00;
         end else begin
            quot_d = qs_q ? -dvd_q : dvd_q;
            rem_d  = rs_q ? -prem_q[7:0] : prem_q[7:0];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dvd_q    <= 16'd0;
         dmag_q   <= 8'd0;
         prem_q   <= 9'd0;
         cnt_q    <= 5'd0;
         qs_q     <= 1'b0;
         rs_q     <= 1'b0;
         dz_q     <= 1'b0;
         ov_q     <= 1'b0;
         quot_q   <= 16'd0;
         rem_q    <= 8'd0;
         valid_q  <= 1'b0;
         dz_out_q <= 1'b0;
         ov_out_q <= 1'b0;
      end else begin
         dvd_q    <= dvd_d;
         dmag_q   <= dmag_d;
         prem_q   <= prem_d;
         cnt_q    <= cnt_d;
         qs_q     <= qs_d;
         rs_q     <= rs_d;
         dz_q     <= dz_d;
         ov_q     <= ov_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         valid_q  <= valid_d;
         dz_out_q <= dz_out_d;
         ov_out_q <= ov_out_d;
      end
   end

   assign Quotient       = quot_q;
   assign Remainder      = rem_q;
   assign Quotient_Valid = valid_q;
   assign Div_Zero       = dz_out_q;
   assign Overflow       = ov_out_q;

endmodule

// File: tb/tb_serial_div.sv
// Bench for serial_div: scenario tasks plus a scoreboard of expected results checked on each
// valid pulse.
module tb_serial_div;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Start;
   logic [15:0] in_n;
   logic [7:0]  in_d;
   logic [15:0] Quotient;
   logic [7:0]  Remainder;
   logic        Busy;
   logic        Quotient_Valid;
   logic        Div_Zero;
   logic        Overflow;

   typedef struct packed {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      logic        ov;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   serial_div dut (
      .CLK            (CLK),
      .RST            (RST),
      .Start          (Start),
      .in_n           (in_n),
      .in_d           (in_d),
      .Quotient       (Quotient),
      .Remainder      (Remainder),
      .Busy           (Busy),
      .Quotient_Valid (Quotient_Valid),
      .Div_Zero       (Div_Zero),
      .Overflow       (Overflow)
   );

   always #5 CLK = ~CLK;

   // Reference: truncating signed division plus the two special cases.
   function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
      exp_t e;
      int   ni, di, q, r;
      ni = $signed(n);
      di = $signed(d);
      e  = '0;
      if (di == 0) begin
         e.q  = (ni < 0) ? 16'h8000 : 16'h7FFF;
         e.dz = 1'b1;
      end else if (ni == -32768 && di == -1) begin
         e.q  = 16'h8000;
         e.ov = 1'b1;
      end else begin
         q   = ni / di;
         r   = ni % di;
         e.q = q[15:0];
         e.r = r[7:0];
      end
      return e;
   endfunction

   // Scoreboard: every valid pulse pops one expected result.
   always @(posedge CLK) begin
      #1;
      if (Quotient_Valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_valid: got q=%h r=%h, required no valid pulse",
                     Quotient, Remainder);
         end else begin
            mon_e = sb.pop_front();
            if ({Quotient, Remainder, Div_Zero, Overflow} !== {mon_e.q, mon_e.r, mon_e.dz, mon_e.ov}) begin
               errors++;
               $display("FAIL sb_result: got q=%h r=%h dz=%b ov=%b, required q=%h r=%h dz=%b ov=%b",
                        Quotient, Remainder, Div_Zero, Overflow,
                        mon_e.q, mon_e.r, mon_e.dz, mon_e.ov);
            end
         end
      end
   end

   // Drives one Start pulse; returns #1 after the load edge E0.
   task automatic issue(input logic [15:0] n, input logic [7:0] d);
      @(negedge CLK);
      in_n  = n;
      in_d  = d;
      Start = 1'b1;
      sb.push_back(model(n, d));
      @(posedge CLK);
      #1;
      Start = 1'b0;
   endtask

   // Counts edges after E0 until a valid pulse; 40 if none arrives.
   task automatic wait_valid(output int lat);
      lat = 40;
      for (int i = 1; i <= 40; i++) begin
         @(posedge CLK);
         #1;
         if (Quotient_Valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RST   = 1'b1;
      Start = 1'b0;
      in_n  = '0;
      in_d  = '0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if ({Quotient, Remainder, Busy, Quotient_Valid, Div_Zero, Overflow} !== 28'd0) begin
         errors++;
         $display("FAIL reset_outputs: got q=%h r=%h busy=%b v=%b dz=%b ov=%b, required all 0",
                  Quotient, Remainder, Busy, Quotient_Valid, Div_Zero, Overflow);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_basic;
      int lat, busy_cnt;
      issue(16'd1000, 8'd7);
      busy_cnt = (Busy === 1'b1) ? 1 : 0;
      lat = 40;
      for (int i = 1; i <= 40; i++) begin
         @(posedge CLK);
         #1;
         if (Quotient_Valid === 1'b1) begin
            lat = i;
            break;
         end
         if (Busy === 1'b1) busy_cnt++;
      end
      checks++;
      if (lat != 17) begin
         errors++;
         $display("FAIL basic_latency: got %0d, required 17", lat);
      end
      checks++;
      if (busy_cnt != 17) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d, required 17", busy_cnt);
      end
      checks++;
      if (Quotient !== 16'h008E || Remainder !== 8'h06 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got q=%h r=%h busy=%b, required q=008e r=06 busy=0",
                  Quotient, Remainder, Busy);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (Quotient_Valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse_width: got valid=%b one cycle later, required 0",
                  Quotient_Valid);
      end
   endtask

   task automatic test_signs;
      logic [15:0] tn[3] = '{16'hFC18, 16'd1000, 16'hFC18};
      logic [7:0]  td[3] = '{8'd7, 8'hF9, 8'hF9};
      logic [15:0] tq[3] = '{16'hFF72, 16'hFF72, 16'h008E};
      logic [7:0]  tr[3] = '{8'hFA, 8'h06, 8'hFA};
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue(tn[i], td[i]);
         wait_valid(lat);
         checks++;
         if (lat != 17 || Quotient !== tq[i] || Remainder !== tr[i]) begin
            errors++;
            $display("FAIL signs_%0d: got lat=%0d q=%h r=%h, required lat=17 q=%h r=%h",
                     i, lat, Quotient, Remainder, tq[i], tr[i]);
         end
      end
   endtask

   task automatic test_extremes;
      logic [15:0] tn[3] = '{16'h8000, 16'h8000, 16'h7FFF};
      logic [7:0]  td[3] = '{8'h80, 8'hFF, 8'h01};
      logic [15:0] tq[3] = '{16'h0100, 16'h8000, 16'h7FFF};
      logic        tov[3] = '{1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue(tn[i], td[i]);
         wait_valid(lat);
         checks++;
         if (lat != 17 || Quotient !== tq[i] || Remainder !== 8'h00 || Overflow !== tov[i]
             || Div_Zero !== 1'b0) begin
            errors++;
            $display("FAIL extremes_%0d: got lat=%0d q=%h r=%h ov=%b dz=%b, required lat=17 q=%h r=00 ov=%b dz=0",
                     i, lat, Quotient, Remainder, Overflow, Div_Zero, tq[i], tov[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      logic [15:0] tn[2] = '{16'd5, 16'hFFFB};
      logic [15:0] tq[2] = '{16'h7FFF, 16'h8000};
      int lat;
      for (int i = 0; i < 2; i++) begin
         issue(tn[i], 8'h00);
         wait_valid(lat);
         checks++;
         if (lat != 17 || Quotient !== tq[i] || Remainder !== 8'h00 || Div_Zero !== 1'b1
             || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_%0d: got lat=%0d q=%h r=%h dz=%b ov=%b, required lat=17 q=%h r=00 dz=1 ov=0",
                     i, lat, Quotient, Remainder, Div_Zero, Overflow, tq[i]);
         end
      end
   endtask

   task automatic test_ignore_start;
      logic [15:0] prev_q;
      int lat, extra;
      prev_q = Quotient;
      issue(16'd1000, 8'd7);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      in_n  = 16'd5;
      in_d  = 8'h00;
      Start = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      Start = 1'b0;
      checks++;
      if (Busy !== 1'b1 || Quotient !== prev_q || Div_Zero !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start_hold: got busy=%b q=%h dz=%b, required busy=1 q=%h dz=1",
                  Busy, Quotient, Div_Zero, prev_q);
      end
      wait_valid(lat);
      checks++;
      if (lat != 12 || Quotient !== 16'h008E || Remainder !== 8'h06 || Div_Zero !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_result: got lat=%0d q=%h r=%h dz=%b, required lat=12 q=008e r=06 dz=0",
                  lat, Quotient, Remainder, Div_Zero);
      end
      extra = 0;
      repeat (25) begin
         @(posedge CLK);
         #1;
         if (Quotient_Valid === 1'b1 || Busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL ignore_start_no_second_op: got %0d active cycles, required 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      int v[2];
      int k, extra;
      v = '{0, 0};
      k = 0;
      @(negedge CLK);
      in_n  = 16'hFC18;
      in_d  = 8'hF9;
      Start = 1'b1;
      sb.push_back(model(16'hFC18, 8'hF9));
      sb.push_back(model(16'hFC18, 8'hF9));
      @(posedge CLK);
      for (int e = 1; e <= 40; e++) begin
         @(posedge CLK);
         #1;
         if (Quotient_Valid === 1'b1) begin
            v[k] = e;
            k++;
            if (k == 2) break;
         end
      end
      Start = 1'b0;
      checks++;
      if (v[0] != 17 || v[1] != 35) begin
         errors++;
         $display("FAIL back_to_back_edges: got %0d,%0d, required 17,35", v[0], v[1]);
      end
      extra = 0;
      repeat (10) begin
         @(posedge CLK);
         #1;
         if (Quotient_Valid === 1'b1 || Quotient !== 16'h008E || Remainder !== 8'hFA) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL outputs_hold: got %0d disturbed cycles (q=%h r=%h), required 0 (q=008e r=fa)",
                  extra, Quotient, Remainder);
      end
   endtask

   task automatic test_reset_mid;
      int lat, extra;
      issue(16'd1000, 8'd7);
      repeat (8) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      checks++;
      if ({Quotient, Remainder, Busy, Quotient_Valid, Div_Zero, Overflow} !== 28'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got q=%h r=%h busy=%b v=%b dz=%b ov=%b, required all 0",
                  Quotient, Remainder, Busy, Quotient_Valid, Div_Zero, Overflow);
      end
      sb.delete();
      @(negedge CLK);
      RST = 1'b0;
      extra = 0;
      repeat (30) begin
         @(posedge CLK);
         #1;
         if (Quotient_Valid === 1'b1 || Busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL reset_mid_no_valid: got %0d active cycles, required 0", extra);
      end
      issue(16'd1000, 8'd7);
      wait_valid(lat);
      checks++;
      if (lat != 17 || Quotient !== 16'h008E || Remainder !== 8'h06) begin
         errors++;
         $display("FAIL reset_mid_rerun: got lat=%0d q=%h r=%h, required lat=17 q=008e r=06",
                  lat, Quotient, Remainder);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_extremes();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge CLK);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drained: got %0d pending results, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
